// File: rtl/operand_fetcher_pkg.sv
// Shared types and helpers for the operand fetcher.
//   state_t    : FSM encoding (IDLE, FETCH, DONE)
//   cnt_width  : width of a count field able to hold 0..max_bytes
package operand_fetcher_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      DONE  = 2'd2
   } state_t;

   function automatic int cnt_width(input int max_bytes);
      return $clog2(max_bytes + 1);
   endfunction

endpackage

// File: rtl/operand_fetcher_byte_extender.sv
// Combinational widening of a little-endian byte array to a full operand.
// Lanes below n pass through; lanes at and above n are filled with the sign
// of byte n-1 when sign_extend is set, otherwise with zero. n=0 gives zero.
//   bytes        in   MAX_BYTES x 8   assembled byte lanes
//   n            in   CNT_W           number of valid lanes
//   sign_extend  in   1               1: sign fill, 0: zero fill
//   operand      out  8*MAX_BYTES     extended result
module byte_extender
   import operand_fetcher_pkg::*;
#(
   parameter int MAX_BYTES = 4,
   parameter int CNT_W     = cnt_width(MAX_BYTES)
) (
   input  logic [MAX_BYTES-1:0][7:0] bytes,
   input  logic [CNT_W-1:0]          n,
   input  logic                      sign_extend,
   output logic [8*MAX_BYTES-1:0]    operand
);

   logic [7:0] fill;

   always_comb begin
      fill    = 8'h00;
      operand = '0;
      // Pick the sign from the last valid lane without a variable-width index.
      for (int i = 0; i < MAX_BYTES; i++) begin
         if (sign_extend && (n == CNT_W'(i + 1))) fill = {8{bytes[i][7]}};
      end
      for (int i = 0; i < MAX_BYTES; i++) begin
         operand[8*i +: 8] = (CNT_W'(i) < n) ? bytes[i] : fill;
      end
   end

endmodule

// File: rtl/operand_fetcher.sv
// Pops 0..MAX_BYTES operand bytes from the prefetch byte FIFO, assembles them
// little-endian and sign/zero-extends the result for the decoder.
//   clk, reset    clock, asynchronous active-high reset
//   start         request a fetch (accepted only in IDLE, without flush)
//   num_bytes     byte count, saturated to MAX_BYTES, sampled on accept
//   sign_extend   extension mode, sampled on accept
//   flush         synchronous abort of an in-flight fetch
//   busy          fetch in progress
//   complete      one-cycle pulse, operand valid
//   operand       extended result, held until the next complete
//   fifo_rd_en    pop strobe; data returns on fifo_rd_data one cycle later
//   fifo_rd_data  popped byte
//   fifo_empty    FIFO has no byte available
//
// state | meaning
// IDLE  | waiting for start; first pop may be issued in the accept cycle
// FETCH | issuing pops and capturing returned bytes into lanes
// DONE  | operand registered, complete high for this one cycle
module operand_fetcher
   import operand_fetcher_pkg::*;
#(
   parameter int MAX_BYTES = 4,
   parameter int CNT_W     = cnt_width(MAX_BYTES)
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   start,
   input  logic [CNT_W-1:0]       num_bytes,
   input  logic                   sign_extend,
   input  logic                   flush,
   output logic                   busy,
   output logic                   complete,
   output logic [8*MAX_BYTES-1:0] operand,
   output logic                   fifo_rd_en,
   input  logic [7:0]             fifo_rd_data,
   input  logic                   fifo_empty
);

   localparam logic [CNT_W-1:0] MAX_N = CNT_W'(MAX_BYTES);

   state_t                    state;
   logic [CNT_W-1:0]          n_q;
   logic                      sx_q;
   logic [CNT_W-1:0]          issue_cnt;
   logic [CNT_W-1:0]          cap_cnt;
   logic                      pop_d;
   logic [MAX_BYTES-1:0][7:0] lanes;
   logic [MAX_BYTES-1:0][7:0] lanes_nxt;
   logic [CNT_W-1:0]          n_sat;
   logic [CNT_W-1:0]          n_req;
   logic [CNT_W-1:0]          issued;
   logic                      accept;
   logic                      capture;
   logic                      last_capture;
   logic [8*MAX_BYTES-1:0]    extended;

   assign n_sat  = (num_bytes > MAX_N) ? MAX_N : num_bytes;
   assign accept = (state == IDLE) && start && !flush;

   // In IDLE the counters are about to be cleared and n comes straight from
   // the port, so the accept-cycle pop sees a fresh fetch.
   assign n_req  = (state == IDLE) ? n_sat : n_q;
   assign issued = (state == IDLE) ? '0 : issue_cnt;

   assign fifo_rd_en = !reset && !fifo_empty && !flush && (issued < n_req) &&
                       ((state == FETCH) || ((state == IDLE) && start));

   // Data from a pop issued before a flush is dropped here.
   assign capture      = (state == FETCH) && pop_d && !flush;
   assign last_capture = capture && (cap_cnt == (n_q - CNT_W'(1)));

   always_comb begin
      lanes_nxt = lanes;
      for (int i = 0; i < MAX_BYTES; i++) begin
         if (capture && (cap_cnt == CNT_W'(i))) lanes_nxt[i] = fifo_rd_data;
      end
   end

   // Fed with the next-cycle lanes so the final byte lands in the operand on
   // the same edge that enters DONE.
   byte_extender #(
      .MAX_BYTES (MAX_BYTES),
      .CNT_W     (CNT_W)
   ) u_byte_extender (
      .bytes       (lanes_nxt),
      .n           (n_q),
      .sign_extend (sx_q),
      .operand     (extended)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         n_q       <= '0;
         sx_q      <= 1'b0;
         issue_cnt <= '0;
         cap_cnt   <= '0;
         pop_d     <= 1'b0;
         lanes     <= '0;
         busy      <= 1'b0;
         complete  <= 1'b0;
         operand   <= '0;
      end else begin
         pop_d    <= fifo_rd_en;
         lanes    <= lanes_nxt;
         complete <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) begin
                  n_q       <= n_sat;
                  sx_q      <= sign_extend;
                  cap_cnt   <= '0;
                  issue_cnt <= fifo_rd_en ? CNT_W'(1) : '0;
                  if (n_sat == '0) begin
                     state    <= DONE;
                     complete <= 1'b1;
                     operand  <= '0;
                  end else begin
                     state <= FETCH;
                     busy  <= 1'b1;
                  end
               end
            end
            FETCH: begin
               if (flush) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end else begin
                  if (fifo_rd_en) issue_cnt <= issue_cnt + CNT_W'(1);
                  if (capture)    cap_cnt   <= cap_cnt + CNT_W'(1);
                  if (last_capture) begin
                     state    <= DONE;
                     busy     <= 1'b0;
                     complete <= 1'b1;
                     operand  <= extended;
                  end
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_operand_fetcher.sv
// Directed bench for operand_fetcher with a small byte-FIFO model that returns
// data one cycle after each pop and can be forced empty for a stall window.
module tb_operand_fetcher;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [2:0]  num_bytes;
   logic        sign_extend;
   logic        flush;
   logic        busy;
   logic        complete;
   logic [31:0] operand;
   logic        fifo_rd_en;
   logic [7:0]  fifo_rd_data = 8'h00;
   logic        fifo_empty;

   int checks = 0;
   int errors = 0;

   logic [7:0] mem [0:63];
   int wr_ptr    = 0;
   int rd_ptr    = 0;
   int pops      = 0;
   int stall_at  = 0;
   int stall_len = 0;
   int stall_cnt = 0;

   always #5 clk = ~clk;

   operand_fetcher #(.MAX_BYTES(4)) dut (
      .clk          (clk),
      .reset        (reset),
      .start        (start),
      .num_bytes    (num_bytes),
      .sign_extend  (sign_extend),
      .flush        (flush),
      .busy         (busy),
      .complete     (complete),
      .operand      (operand),
      .fifo_rd_en   (fifo_rd_en),
      .fifo_rd_data (fifo_rd_data),
      .fifo_empty   (fifo_empty)
   );

   assign fifo_empty = (rd_ptr == wr_ptr) || (stall_cnt != 0);

   always @(posedge clk) begin
      if (fifo_rd_en) begin
         fifo_rd_data <= mem[rd_ptr[5:0]];
         rd_ptr       <= rd_ptr + 1;
         pops         <= pops + 1;
         if ((stall_at != 0) && (pops + 1 == stall_at)) stall_cnt <= stall_len;
      end else if (stall_cnt != 0) begin
         stall_cnt <= stall_cnt - 1;
      end
   end

   task automatic push(input logic [7:0] b);
      mem[wr_ptr[5:0]] = b;
      wr_ptr = wr_ptr + 1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Starts a fetch, then watches cycle by cycle (cycle 0 = start cycle).
   task automatic run(input string tag, input logic [2:0] n, input logic sx,
                      input logic [31:0] exp_op, input int exp_lat,
                      input logic exp_busy1, input int exp_pops);
      int   base;
      int   lat;
      logic got;
      base = pops;
      got  = 1'b0;
      lat  = -1;
      @(posedge clk); #1;
      start = 1'b1; num_bytes = n; sign_extend = sx;
      for (int c = 0; c < 40 && !got; c++) begin
         @(negedge clk);
         if (c == 1) check({tag, " busy@1"}, {31'd0, busy}, {31'd0, exp_busy1});
         if (complete) begin
            got = 1'b1;
            lat = c;
            check({tag, " busy@done"}, {31'd0, busy}, 32'd0);
         end
         @(posedge clk); #1;
         start = 1'b0;
      end
      check({tag, " latency"}, lat, exp_lat);
      check({tag, " operand"}, operand, exp_op);
      @(negedge clk);
      check({tag, " complete pulse"}, {31'd0, complete}, 32'd0);
      check({tag, " pops"}, pops - base, exp_pops);
   endtask

   initial begin
      int   base;
      int   lat;
      logic seen;

      reset = 1'b1; start = 1'b0; num_bytes = 3'd0; sign_extend = 1'b0; flush = 1'b0;
      #2;
      check("reset busy",     {31'd0, busy},       32'd0);
      check("reset complete", {31'd0, complete},   32'd0);
      check("reset operand",  operand,             32'd0);
      check("reset rd_en",    {31'd0, fifo_rd_en}, 32'd0);
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;

      // 1: single byte, sign-extended
      push(8'h80);
      run("t1 n1 sx", 3'd1, 1'b1, 32'hFFFF_FF80, 2, 1'b1, 1);

      // 2: two bytes, zero-extended
      push(8'h34); push(8'h92);
      run("t2 n2 zx", 3'd2, 1'b0, 32'h0000_9234, 3, 1'b1, 2);

      // sign fill comes from the last byte, not the first
      push(8'hFF); push(8'h7F);
      run("t2b n2 sx", 3'd2, 1'b1, 32'h0000_7FFF, 3, 1'b1, 2);

      // 4: zero bytes, sign mode irrelevant
      run("t4 n0", 3'd0, 1'b1, 32'h0000_0000, 1, 1'b0, 0);

      // 3: four bytes with a 3-cycle empty window after the first pop
      push(8'h78); push(8'h56); push(8'h34); push(8'h12);
      stall_at  = pops + 1;
      stall_len = 3;
      run("t3 stall", 3'd4, 1'b0, 32'h1234_5678, 8, 1'b1, 4);
      stall_at  = 0;

      // oversize count saturates to 4 bytes
      push(8'h01); push(8'h02); push(8'h03); push(8'h84);
      run("sat n7", 3'd7, 1'b1, 32'h8403_0201, 5, 1'b1, 4);

      // 5: flush after two pops
      push(8'h11); push(8'h22); push(8'h33); push(8'h44);
      base = pops;
      @(posedge clk); #1;
      start = 1'b1; num_bytes = 3'd4; sign_extend = 1'b0;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #1;
      flush = 1'b1;
      @(negedge clk);
      check("t5 rd_en in flush", {31'd0, fifo_rd_en}, 32'd0);
      @(posedge clk); #1;
      flush = 1'b0;
      @(negedge clk);
      check("t5 busy after flush", {31'd0, busy}, 32'd0);
      seen = 1'b0;
      repeat (6) begin
         @(negedge clk);
         if (complete) seen = 1'b1;
      end
      check("t5 no complete", {31'd0, seen}, 32'd0);
      check("t5 operand held", operand, 32'h8403_0201);
      check("t5 pops", pops - base, 2);
      run("t5 next n1", 3'd1, 1'b0, 32'h0000_0033, 2, 1'b1, 1);

      // 6: reset mid-fetch with start held high; FIFO now holds 44
      push(8'hA1); push(8'h5A); push(8'hC3);
      base = pops;
      @(posedge clk); #1;
      start = 1'b1; num_bytes = 3'd4; sign_extend = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      reset = 1'b1;
      #1;
      check("t6 rst busy",     {31'd0, busy},       32'd0);
      check("t6 rst complete", {31'd0, complete},   32'd0);
      check("t6 rst operand",  operand,             32'd0);
      check("t6 rst rd_en",    {31'd0, fifo_rd_en}, 32'd0);
      check("t6 pops before reset", pops - base, 2);
      push(8'h0F); push(8'h7E);
      @(posedge clk); #1;
      @(posedge clk); #1;
      reset = 1'b0;
      base = pops;
      seen = 1'b0;
      lat  = -1;
      for (int c = 0; c < 40 && !seen; c++) begin
         @(negedge clk);
         if (complete) begin
            seen = 1'b1;
            lat  = c;
         end
         @(posedge clk); #1;
         if (c == 2) start = 1'b0;
      end
      check("t6 latency", lat, 5);
      check("t6 operand", operand, 32'h7E0F_C35A);
      repeat (3) @(negedge clk);
      check("t6 pops", pops - base, 4);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
